// File: rtl/eco32_irq_ctrl.sv
// Wishbone-B3 interrupt controller for the eco32f: per-source level/edge mode,
// pending latch with write-1-to-clear, mask, and a lowest-index vector register.
module eco32_irq_ctrl #(
   parameter int NUM_IRQ = 16
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic [2:0]  wb_cti_i,
   input  logic [1:0]  wb_bte_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        wb_err_o,
   output logic        wb_rty_o,
   input  logic [15:0] irq_src_i,
   output logic [15:0] irq_o
);

   localparam logic [15:0] VM = 16'((32'd1 << NUM_IRQ) - 32'd1);

   logic [15:0] raw_q, raw_qq, lat, mask_q, edge_q;
   logic [15:0] rise, pend, act, w1c, lat_nxt;
   logic [3:0]  vec_idx;
   logic [2:0]  sel;
   logic        req, mapped, wr;
   logic [31:0] rd_data;
   logic        unused_ok;

   assign unused_ok = ^{wb_sel_i, wb_cti_i, wb_bte_i, wb_adr_i[31:5], wb_adr_i[1:0]};
   assign wb_rty_o  = 1'b0;

   assign sel    = wb_adr_i[4:2];
   assign req    = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
   assign mapped = (sel <= 3'd4);
   assign wr     = req & wb_we_i & mapped;

   assign rise = raw_q & ~raw_qq;
   assign pend = (edge_q & lat) | (~edge_q & raw_q);
   assign act  = pend & mask_q;
   assign w1c  = (wr && sel == 3'd1) ? (wb_dat_i[15:0] & VM) : 16'h0;
   // A rise in the same cycle as a W1C wins so no edge is ever lost.
   assign lat_nxt = edge_q & (rise | (lat & ~w1c));

   always_comb begin
      vec_idx = 4'd0;
      for (int i = 15; i >= 0; i--)
         if (act[i]) vec_idx = 4'(i);
   end

   always_comb begin
      rd_data = 32'h0;
      case (sel)
         3'd0: rd_data = {16'h0, raw_q};
         3'd1: rd_data = {16'h0, pend};
         3'd2: rd_data = {16'h0, mask_q};
         3'd3: rd_data = {16'h0, edge_q};
         3'd4: rd_data = {|act, 27'h0, vec_idx};
         default: rd_data = 32'h0;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         raw_q  <= '0;
         raw_qq <= '0;
         lat    <= '0;
         mask_q <= '0;
         edge_q <= '0;
         irq_o  <= '0;
      end else begin
         raw_q  <= irq_src_i & VM;
         raw_qq <= raw_q;
         lat    <= lat_nxt;
         irq_o  <= act;
         if (wr && sel == 3'd2) mask_q <= wb_dat_i[15:0] & VM;
         if (wr && sel == 3'd3) edge_q <= wb_dat_i[15:0] & VM;
      end
   end

   // One wait state: the handshake flops also gate the next request.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wb_ack_o <= 1'b0;
         wb_err_o <= 1'b0;
         wb_dat_o <= 32'h0;
      end else begin
         wb_ack_o <= req & mapped;
         wb_err_o <= req & ~mapped;
         if (req) wb_dat_o <= mapped ? rd_data : 32'h0;
      end
   end

endmodule

// File: tb/tb_eco32_irq_ctrl.sv
// Directed bench for eco32_irq_ctrl: register map, level/edge latency, W1C race,
// vector priority, bus ack cadence and asynchronous reset.
module tb_eco32_irq_ctrl;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic [31:0] wb_adr_i = '0;
   logic [31:0] wb_dat_i = '0;
   logic [3:0]  wb_sel_i = 4'hF;
   logic        wb_we_i  = 1'b0;
   logic        wb_cyc_i = 1'b0;
   logic        wb_stb_i = 1'b0;
   logic [2:0]  wb_cti_i = '0;
   logic [1:0]  wb_bte_i = '0;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o, wb_err_o, wb_rty_o;
   logic [15:0] irq_src_i = '0;
   logic [15:0] irq_o;

   int tests = 0;
   int fails = 0;
   logic [31:0] rd;
   logic        ak, er;

   eco32_irq_ctrl #(.NUM_IRQ(16)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
      .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
      .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
      .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o), .irq_src_i(irq_src_i), .irq_o(irq_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   task automatic tick;
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Single access: request sampled at the first edge, ack visible after it.
   task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      output logic [31:0] rdat, output logic ack, output logic err);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
      tick;
      rdat = wb_dat_o; ack = wb_ack_o; err = wb_err_o;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      tick;
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
      logic [31:0] d;
      logic a, e;
      bus(1'b0, adr, 32'h0, d, a, e);
      chk({tag, "_ack"}, {31'h0, a}, 32'h1);
      chk(tag, d, exp);
   endtask

   task automatic wr_reg(input logic [31:0] adr, input logic [31:0] dat);
      logic [31:0] d;
      logic a, e;
      bus(1'b1, adr, dat, d, a, e);
      chk("wr_ack", {31'h0, a}, 32'h1);
   endtask

   initial begin
      // 1: reset and register map
      tick; tick;
      chk("rst_irq", {16'h0, irq_o}, 32'h0);
      chk("rst_ack", {31'h0, wb_ack_o}, 32'h0);
      wb_rst_i = 1'b0;
      tick;
      for (int i = 0; i < 5; i++) rd_chk("rst_reg", 32'(i * 4), 32'h0);
      bus(1'b0, 32'h14, 32'h0, rd, ak, er);
      chk("unm_err", {31'h0, er}, 32'h1);
      chk("unm_ack", {31'h0, ak}, 32'h0);
      chk("unm_dat", rd, 32'h0);
      chk("unm_err_1cyc", {31'h0, wb_err_o}, 32'h0);

      // 2: level mode latency and vector
      wr_reg(32'h08, 32'h4000);
      irq_src_i = 16'h4000;
      tick;
      chk("lvl_k", {16'h0, irq_o}, 32'h0);
      tick;
      chk("lvl_k1", {16'h0, irq_o}, 32'h4000);
      rd_chk("lvl_vec", 32'h10, 32'h8000000E);
      rd_chk("lvl_raw", 32'h00, 32'h4000);
      irq_src_i = 16'h0;
      tick;
      chk("lvl_drop1", {16'h0, irq_o}, 32'h4000);
      tick;
      chk("lvl_drop2", {16'h0, irq_o}, 32'h0);

      // 3: edge mode pulse capture and W1C
      wr_reg(32'h0C, 32'h0001);
      wr_reg(32'h08, 32'h0001);
      irq_src_i = 16'h0001;
      tick;
      irq_src_i = 16'h0000;
      tick;
      chk("edg_k1", {16'h0, irq_o}, 32'h0);
      tick;
      chk("edg_k2", {16'h0, irq_o}, 32'h1);
      rd_chk("edg_pend", 32'h04, 32'h1);
      wr_reg(32'h04, 32'h1);
      chk("edg_w1c", {16'h0, irq_o}, 32'h0);
      rd_chk("edg_pend_clr", 32'h04, 32'h0);

      // 4: rise coincides with W1C -> set wins; vector priority
      irq_src_i = 16'h0001; tick; tick;
      irq_src_i = 16'h0000; tick; tick;
      irq_src_i = 16'h0001; tick;
      irq_src_i = 16'h0000;
      bus(1'b1, 32'h04, 32'h1, rd, ak, er);
      chk("race_ack", {31'h0, ak}, 32'h1);
      rd_chk("race_pend", 32'h04, 32'h1);
      wr_reg(32'h04, 32'h1);
      irq_src_i = 16'h0208;
      wr_reg(32'h08, 32'h0208);
      tick; tick;
      rd_chk("prio_vec", 32'h10, 32'h80000003);
      chk("prio_irq", {16'h0, irq_o}, 32'h0208);

      // 5: masking and clearing EDGE on a latched bit
      wr_reg(32'h08, 32'h0);
      irq_src_i = 16'h0020;
      tick; tick;
      chk("msk_irq0", {16'h0, irq_o}, 32'h0);
      rd_chk("msk_raw", 32'h00, 32'h20);
      rd_chk("msk_pend", 32'h04, 32'h20);
      wr_reg(32'h08, 32'h20);
      chk("msk_irq1", {16'h0, irq_o}, 32'h20);
      irq_src_i = 16'h0021; tick;
      irq_src_i = 16'h0020; tick; tick;
      rd_chk("edg_latched", 32'h04, 32'h21);
      wr_reg(32'h0C, 32'h0);
      wr_reg(32'h0C, 32'h1);
      rd_chk("edg_cleared", 32'h04, 32'h20);

      // 6: back-to-back stream, then reset mid-access
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h08;
      chk("b2b_0", {31'h0, wb_ack_o}, 32'h0);
      for (int i = 0; i < 4; i++) begin
         tick;
         chk("b2b_ack", {31'h0, wb_ack_o}, (i % 2 == 0) ? 32'h1 : 32'h0);
         if (i % 2 == 0) chk("b2b_dat", wb_dat_o, 32'h20);
      end
      tick;
      #1 wb_rst_i = 1'b1;
      #1;
      chk("arst_ack", {31'h0, wb_ack_o}, 32'h0);
      chk("arst_irq", {16'h0, irq_o}, 32'h0);
      chk("arst_dat", wb_dat_o, 32'h0);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      irq_src_i = 16'h0;
      tick;
      wb_rst_i = 1'b0;
      tick;
      chk("post_ack", {31'h0, wb_ack_o}, 32'h0);
      tick;
      chk("post_ack2", {31'h0, wb_ack_o}, 32'h0);
      chk("post_err", {31'h0, wb_err_o}, 32'h0);
      rd_chk("post_mask", 32'h08, 32'h0);
      rd_chk("post_edge", 32'h0C, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
